// File: rtl/ex_div_radix.sv
// Iterative restoring integer divider (signed/unsigned) for the EX stage.
// Retires BITS_PER_CYCLE quotient bits per clock; result is {remainder, quotient}.
module ex_div_radix #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     operand1,
  input  logic [WIDTH-1:0]     operand2,
  input  logic                 is_start,
  input  logic                 is_annul,
  output logic                 is_ended,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero,
  output logic                 busy
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {FREE, BY_ZERO, ON, FIXUP, END} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cycle;
  logic [WIDTH-1:0]   r_rem, r_quo, r_div;
  logic               r_neg_q, r_neg_r, r_dz_pend;
  logic               r_is_ended, r_dz, r_busy;
  logic [2*WIDTH-1:0] r_result;
  logic [WIDTH-1:0]   w_rem_nx, w_quo_nx, w_mag1, w_mag2;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  assign w_mag1 = (is_signed && operand1[WIDTH-1]) ? negate(operand1) : operand1;
  assign w_mag2 = (is_signed && operand2[WIDTH-1]) ? negate(operand2) : operand2;

  // r_quo starts as the dividend and is shifted out MSB-first while quotient bits shift in.
  always_comb begin
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] trial;
    rem   = r_rem;
    quo   = r_quo;
    sh    = '0;
    trial = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      sh    = {rem, quo[WIDTH-1]};
      trial = {1'b0, sh} - {2'b00, r_div};
      if (trial[WIDTH+1]) begin
        rem = sh[WIDTH-1:0];
        quo = {quo[WIDTH-2:0], 1'b0};
      end else begin
        rem = trial[WIDTH-1:0];
        quo = {quo[WIDTH-2:0], 1'b1};
      end
    end
    w_rem_nx = rem;
    w_quo_nx = quo;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FREE:    if (is_start && !is_annul) w_next = (operand2 == '0) ? BY_ZERO : ON;
      BY_ZERO: w_next = is_annul ? FREE : END;
      ON: begin
        if (is_annul)                     w_next = FREE;
        else if (r_cycle == CW'(N - 1))   w_next = FIXUP;
      end
      FIXUP:   w_next = is_annul ? FREE : END;
      END:     if (r_is_ended && !is_start) w_next = FREE;
      default: w_next = FREE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= FREE;
      r_busy     <= 1'b0;
      r_cycle    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_is_ended <= 1'b0;
      r_dz       <= 1'b0;
      r_result   <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != FREE);
      case (r_state)
        FREE: if (w_next != FREE) begin
          r_rem     <= '0;
          r_quo     <= w_mag1;
          r_div     <= w_mag2;
          r_cycle   <= '0;
          r_neg_q   <= is_signed & (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
          r_neg_r   <= is_signed & operand1[WIDTH-1];
          r_dz_pend <= (w_next == BY_ZERO);
        end
        BY_ZERO: begin
          r_rem     <= '0;
          r_quo     <= '0;
          r_dz_pend <= 1'b1;
        end
        ON: if (!is_annul) begin
          r_rem   <= w_rem_nx;
          r_quo   <= w_quo_nx;
          r_cycle <= r_cycle + 1'b1;
        end
        FIXUP: begin
          if (r_neg_q) r_quo <= negate(r_quo);
          if (r_neg_r) r_rem <= negate(r_rem);
        end
        END: begin
          if (w_next == FREE) begin
            r_is_ended <= 1'b0;
            r_result   <= '0;
            r_dz       <= 1'b0;
            r_dz_pend  <= 1'b0;
          end else begin
            r_is_ended <= 1'b1;
            r_result   <= {r_rem, r_quo};
            r_dz       <= r_dz_pend;
          end
        end
        default: ;
      endcase
    end
  end

  assign is_ended    = r_is_ended;
  assign result      = r_result;
  assign div_by_zero = r_dz;
  assign busy        = r_busy;

endmodule

// File: tb/tb_ex_div_radix.sv
// Directed and model-checked bench for ex_div_radix: a 32-bit radix-2 instance
// and a 16-bit two-bits-per-cycle instance share clock and reset.
module tb_ex_div_radix;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        sgn32 = 1'b0, start32 = 1'b0, annul32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        end32, dz32, busy32;
  logic [63:0] res32;

  logic        sgn16 = 1'b0, start16 = 1'b0, annul16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        end16, dz16, busy16;
  logic [31:0] res16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_div_radix #(.WIDTH(32), .BITS_PER_CYCLE(1)) u32 (
    .clock(clk), .reset(rst), .is_signed(sgn32), .operand1(a32), .operand2(b32),
    .is_start(start32), .is_annul(annul32), .is_ended(end32), .result(res32),
    .div_by_zero(dz32), .busy(busy32));

  ex_div_radix #(.WIDTH(16), .BITS_PER_CYCLE(2)) u16 (
    .clock(clk), .reset(rst), .is_signed(sgn16), .operand1(a16), .operand2(b16),
    .is_start(start16), .is_annul(annul16), .is_ended(end16), .result(res16),
    .div_by_zero(dz16), .busy(busy16));

  // Reference: 64-bit SV division truncates toward zero, remainder follows dividend.
  function automatic logic [31:0] model16(input logic sgn, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, q, r;
    if (b == 16'h0) return 32'h0;
    if (sgn) begin sa = $signed(a); sb = $signed(b); end
    else     begin sa = a;          sb = b;          end
    q = sa / sb;
    r = sa % sb;
    return {r[15:0], q[15:0]};
  endfunction

  function automatic logic [63:0] model32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin sa = $signed(a); sb = $signed(b); end
    else     begin sa = a;          sb = b;          end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Runs one full handshake; operands are scrambled right after acceptance.
  task automatic op32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                      output logic [63:0] res, output logic dz, output int lat, output logic cleared);
    @(negedge clk);
    sgn32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
    @(posedge clk); #1;
    a32 = $urandom; b32 = $urandom; sgn32 = ~sgn;
    lat = 0;
    while (end32 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = res32; dz = dz32;
    @(negedge clk); start32 = 1'b0;
    @(posedge clk); #1;
    cleared = (end32 === 1'b0) && (res32 === 64'h0) && (dz32 === 1'b0) && (busy32 === 1'b0);
  endtask

  task automatic op16(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                      output logic [31:0] res, output logic dz, output int lat, output logic cleared);
    @(negedge clk);
    sgn16 = sgn; a16 = a; b16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = ~sgn;
    lat = 0;
    while (end16 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = res16; dz = dz16;
    @(negedge clk); start16 = 1'b0;
    @(posedge clk); #1;
    cleared = (end16 === 1'b0) && (res16 === 32'h0) && (dz16 === 1'b0) && (busy16 === 1'b0);
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++; if ({end32, dz32, busy32} !== 3'b000) begin errors++; $display("FAIL reset_flags32 got %b want 000", {end32, dz32, busy32}); end
    checks++; if (res32 !== 64'h0) begin errors++; $display("FAIL reset_result32 got %h want 0", res32); end
    checks++; if ({end16, dz16, busy16, res16} !== 35'h0) begin errors++; $display("FAIL reset16 got %h want 0", {end16, dz16, busy16, res16}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [63:0] res; logic dz, clr; int lat;
    op32(1'b0, 32'd7, 32'd2, res, dz, lat, clr);
    checks++; if (res !== {32'h1, 32'h3}) begin errors++; $display("FAIL u_7_2 got %h want %h", res, {32'h1, 32'h3}); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL u_latency got %0d want 34", lat); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL u_dz got %b want 0", dz); end
    checks++; if (clr !== 1'b1) begin errors++; $display("FAIL u_clear got %b want 1", clr); end
  endtask

  task automatic test_signed;
    logic [63:0] res; logic dz, clr; int lat;
    op32(1'b1, 32'hFFFFFFF9, 32'd2, res, dz, lat, clr);
    checks++; if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin errors++; $display("FAIL s_m7_2 got %h want ffffffff_fffffffd", res); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL s_latency got %0d want 34", lat); end
    op32(1'b1, 32'd7, 32'hFFFFFFFE, res, dz, lat, clr);
    checks++; if (res !== {32'h1, 32'hFFFFFFFD}) begin errors++; $display("FAIL s_7_m2 got %h want 00000001_fffffffd", res); end
    op32(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, res, dz, lat, clr);
    checks++; if (res !== {32'hFFFFFFFF, 32'h3}) begin errors++; $display("FAIL s_m7_m2 got %h want ffffffff_00000003", res); end
  endtask

  task automatic test_div_zero;
    logic [63:0] res; logic dz, clr; int lat;
    op32(1'b0, 32'd5, 32'd0, res, dz, lat, clr);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dz_latency got %0d want 2", lat); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", dz); end
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL dz_result got %h want 0", res); end
    checks++; if (clr !== 1'b1) begin errors++; $display("FAIL dz_clear got %b want 1", clr); end
  endtask

  task automatic test_overflow;
    logic [63:0] res; logic dz, clr; int lat;
    op32(1'b1, 32'h80000000, 32'hFFFFFFFF, res, dz, lat, clr);
    checks++; if (res !== {32'h0, 32'h80000000}) begin errors++; $display("FAIL ovf_signed got %h want 00000000_80000000", res); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL ovf_dz got %b want 0", dz); end
    op32(1'b0, 32'h80000000, 32'hFFFFFFFF, res, dz, lat, clr);
    checks++; if (res !== {32'h80000000, 32'h0}) begin errors++; $display("FAIL ovf_unsigned got %h want 80000000_00000000", res); end
  endtask

  task automatic test_annul;
    int seen;
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); annul32 = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL annul_busy got %b want 0", busy32); end
    // start and annul both high in FREE must not be accepted
    repeat (3) @(posedge clk); #1;
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL start_annul_free busy got %b want 0", busy32); end
    @(negedge clk); annul32 = 1'b0; start32 = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (end32 !== 1'b0 || res32 !== 64'h0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL annul_no_end got %0d cycles with output want 0", seen); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] res; logic dz, clr; int lat;
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL rst_mid_on busy got %b want 0", busy32); end
    @(negedge clk); rst = 1'b0; start32 = 1'b0;
    // reset while a result is displayed must drop it immediately
    @(negedge clk); start32 = 1'b1;
    lat = 0;
    while (end32 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (res32 !== {32'd2, 32'd14}) begin errors++; $display("FAIL rst_pre_result got %h want %h", res32, {32'd2, 32'd14}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({end32, res32} !== 65'h0) begin errors++; $display("FAIL rst_in_end got %h want 0", {end32, res32}); end
    @(negedge clk); rst = 1'b0; start32 = 1'b0;
    op32(1'b0, 32'd100, 32'd7, res, dz, lat, clr);
    checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL retry_100_7 got %h want %h", res, {32'd2, 32'd14}); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL retry_latency got %0d want 34", lat); end
  endtask

  task automatic test_bpc2;
    logic [31:0] res; logic dz, clr; int lat;
    logic [15:0] a, b; logic s;
    int bad;
    op16(1'b0, 16'hFFFF, 16'h0003, res, dz, lat, clr);
    checks++; if (res !== {16'h0, 16'h5555}) begin errors++; $display("FAIL b2_ffff_3 got %h want 00005555", res); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL b2_latency got %0d want 10", lat); end
    checks++; if (clr !== 1'b1) begin errors++; $display("FAIL b2_clear got %b want 1", clr); end
    op16(1'b1, 16'h8000, 16'hFFFF, res, dz, lat, clr);
    checks++; if (res !== {16'h0, 16'h8000}) begin errors++; $display("FAIL b2_ovf got %h want 00008000", res); end
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      case ($urandom_range(0, 15))
        0: b = 16'h0;
        1: b = 16'hFFFF;
        2: a = 16'h8000;
        3: b = 16'($urandom_range(1, 7));
        default: ;
      endcase
      op16(s, a, b, res, dz, lat, clr);
      checks++;
      if (res !== model16(s, a, b) || dz !== (b == 16'h0) || lat !== ((b == 16'h0) ? 2 : 10) || clr !== 1'b1) begin
        errors++; bad++;
        if (bad <= 10) $display("FAIL b2_rand s=%b %h/%h got %h dz=%b lat=%0d want %h", s, a, b, res, dz, lat, model16(s, a, b));
      end
    end
  endtask

  task automatic test_random32;
    logic [63:0] res; logic dz, clr; int lat;
    logic [31:0] a, b; logic s;
    for (int i = 0; i < 200; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i % 4 == 1) b = 32'($urandom_range(1, 1000));
      if (i % 17 == 3) b = 32'h0;
      op32(s, a, b, res, dz, lat, clr);
      checks++;
      if (res !== model32(s, a, b) || dz !== (b == 32'h0) || clr !== 1'b1)
      begin errors++; $display("FAIL r32 s=%b %h/%h got %h dz=%b want %h", s, a, b, res, dz, model32(s, a, b)); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_reset_mid();
    test_bpc2();
    test_random32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
